rv32i_alu: RTL and testbench

- RV32I integer ALU for the single-cycle/pipelined RISC-V core datapath.
- Computes one of ten RV32I arithmetic, logic, shift or compare operations on two 32-bit operands.
- The result and zero flag are combinational, so they are usable in the same cycle for branch decisions.
- An optional registered copy, with a valid flag, feeds a downstream pipeline stage. It is clocked by clk and cleared by asynchronous active-high rst.

---
 rtl/rv32i_alu.sv | 124 ++++++++++++
 tb/tb_rv32i_alu.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_alu.sv
// RV32I integer ALU.
// Ten RV32I arithmetic/logic/shift/compare operations on two XLEN-bit operands.
// result/zero/illegal_op are purely combinational so the core can resolve
// branches in the same cycle; an optional one-deep register stage offers a
// valid-qualified copy of result/zero to the next pipeline stage.
//
// Handshake: in_valid qualifies alu_op/in_a/in_b for the register stage only.
// There is no ready/backpressure; every rising edge with in_valid high
// captures a new result, and out_valid is in_valid delayed by one cycle.
// When in_valid is low the captured result/zero hold their last value.

module rv32i_alu #(
    parameter int XLEN    = 32,
    parameter bit REG_OUT = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      alu_op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic            in_valid,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal_op,
    output logic [XLEN-1:0] result_q,
    output logic            zero_q,
    output logic            out_valid
);

    // alu_op encoding; bit 3 selects the "alternate" form (SUB, SRA).
    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SLL  = 4'b0001;
    localparam logic [3:0] OP_SLT  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;
    localparam logic [3:0] OP_SUB  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1101;

    localparam logic [XLEN-1:0] ONE = {{(XLEN-1){1'b0}}, 1'b1};

    // Only the low five bits of operand B form the shift amount.
    logic [4:0]      w_shamt;
    logic [XLEN-1:0] w_sum;
    logic [XLEN-1:0] w_diff;
    logic [XLEN-1:0] w_sll;
    logic [XLEN-1:0] w_srl;
    logic [XLEN-1:0] w_sra;
    logic            w_lt_signed;
    logic            w_lt_unsigned;
    logic [XLEN-1:0] w_result;
    logic            w_legal;

    assign w_shamt       = in_b[4:0];
    assign w_sum         = in_a + in_b;
    // Two's-complement subtract; wraps modulo 2^XLEN, no carry/overflow kept.
    assign w_diff        = in_a + ~in_b + ONE;
    assign w_sll         = in_a << w_shamt;
    assign w_srl         = in_a >> w_shamt;
    assign w_sra         = $signed(in_a) >>> w_shamt;
    assign w_lt_signed   = $signed(in_a) < $signed(in_b);
    assign w_lt_unsigned = in_a < in_b;

    // Operation select; undefined encodings give 0 and flag illegal.
    always_comb begin
        w_result = '0;
        w_legal  = 1'b1;
        case (alu_op)
            OP_ADD:  w_result = w_sum;
            OP_SUB:  w_result = w_diff;
            OP_SLL:  w_result = w_sll;
            OP_SRL:  w_result = w_srl;
            OP_SRA:  w_result = w_sra;
            OP_SLT:  w_result = {{(XLEN-1){1'b0}}, w_lt_signed};
            OP_SLTU: w_result = {{(XLEN-1){1'b0}}, w_lt_unsigned};
            OP_XOR:  w_result = in_a ^ in_b;
            OP_OR:   w_result = in_a | in_b;
            OP_AND:  w_result = in_a & in_b;
            default: begin
                w_result = '0;
                w_legal  = 1'b0;
            end
        endcase
    end

    assign result     = w_result;
    // zero is suppressed on illegal ops even though the result reads 0.
    assign zero       = w_legal && (w_result == '0);
    assign illegal_op = !w_legal;

    logic [XLEN-1:0] r_result_q;
    logic            r_zero_q;
    logic            r_out_valid;

    generate
        if (REG_OUT) begin : g_reg_out
            // Pipeline copy: capture on valid, hold otherwise, async clear.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_result_q  <= '0;
                    r_zero_q    <= 1'b0;
                    r_out_valid <= 1'b0;
                end else begin
                    r_out_valid <= in_valid;
                    if (in_valid) begin
                        r_result_q <= w_result;
                        r_zero_q   <= zero;
                    end
                end
            end
        end else begin : g_no_reg_out
            assign r_result_q  = '0;
            assign r_zero_q    = 1'b0;
            assign r_out_valid = 1'b0;
        end
    endgenerate

    assign result_q  = r_result_q;
    assign zero_q    = r_zero_q;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_rv32i_alu.sv
// Self-checking bench for rv32i_alu: directed tables for each operation group,
// illegal encodings, randomized combinational checks against a reference model,
// and a scoreboard-checked register stage including asynchronous reset.

module tb_rv32i_alu;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SLL  = 4'b0001;
    localparam logic [3:0] OP_SLT  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;
    localparam logic [3:0] OP_SUB  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1101;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  alu_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_valid;
    logic [31:0] result;
    logic        zero;
    logic        illegal_op;
    logic [31:0] result_q;
    logic        zero_q;
    logic        out_valid;

    int n_tests = 0;
    int n_fail  = 0;

    // Scoreboard entries are {zero, result} expected from the register stage.
    logic [32:0] exp_q[$];

    rv32i_alu #(.XLEN(32), .REG_OUT(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .alu_op     (alu_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_valid   (in_valid),
        .result     (result),
        .zero       (zero),
        .illegal_op (illegal_op),
        .result_q   (result_q),
        .zero_q     (zero_q),
        .out_valid  (out_valid)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic void model_alu(input logic [3:0] op, input logic [31:0] a,
                                      input logic [31:0] b, output logic [31:0] r,
                                      output logic legal);
        logic [4:0] sh;
        sh    = b[4:0];
        legal = 1'b1;
        r     = 32'h0;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_SLL:  r = a << sh;
            OP_SRL:  r = a >> sh;
            OP_SRA: begin
                r = a;
                for (int k = 0; k < 32; k++)
                    if (k < int'(sh)) r = {r[31], r[31:1]};
            end
            OP_SLT:  r = {31'h0, (a[31] != b[31]) ? a[31] : (a < b)};
            OP_SLTU: r = {31'h0, a < b};
            OP_XOR:  r = a ^ b;
            OP_OR:   r = a | b;
            OP_AND:  r = a & b;
            default: legal = 1'b0;
        endcase
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic v);
        @(negedge clk);
        alu_op   = op;
        in_a     = a;
        in_b     = b;
        in_valid = v;
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; alu_op = OP_ADD; in_a = 32'd1; in_b = 32'd2; in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (result_q !== 32'h0 || zero_q !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_regs: got result_q=%h zero_q=%b out_valid=%b want 0/0/0",
                     result_q, zero_q, out_valid);
        end
        n_tests++;
        if (result !== 32'h3) begin
            n_fail++;
            $display("FAIL reset_comb: got result=%h want 00000003", result);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b0;
    endtask

    task automatic test_addsub();
        logic [3:0]  ops[5] = '{OP_SUB, OP_SUB, OP_SUB, OP_ADD, OP_ADD};
        logic [31:0] as[5]  = '{32'h80000000, 32'h12345678, 32'h0, 32'hFFFFFFFF, 32'd2};
        logic [31:0] bs[5]  = '{32'h1, 32'h12345678, 32'h1, 32'h1, 32'd3};
        logic [31:0] er[5]  = '{32'h7FFFFFFF, 32'h0, 32'hFFFFFFFF, 32'h0, 32'd5};
        logic        ez[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            drive(ops[i], as[i], bs[i], 1'b0);
            n_tests++;
            if (result !== er[i] || zero !== ez[i] || illegal_op !== 1'b0) begin
                n_fail++;
                $display("FAIL addsub[%0d]: got result=%h zero=%b ill=%b want result=%h zero=%b ill=0",
                         i, result, zero, illegal_op, er[i], ez[i]);
            end
        end
    endtask

    task automatic test_compare();
        logic [3:0]  ops[4] = '{OP_SLT, OP_SLTU, OP_SLT, OP_SLTU};
        logic [31:0] as[4]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 32'h1};
        logic [31:0] bs[4]  = '{32'h1, 32'h1, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] er[4]  = '{32'h1, 32'h0, 32'h0, 32'h1};
        logic        ez[4]  = '{1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            drive(ops[i], as[i], bs[i], 1'b0);
            n_tests++;
            if (result !== er[i] || zero !== ez[i] || illegal_op !== 1'b0) begin
                n_fail++;
                $display("FAIL compare[%0d]: got result=%h zero=%b ill=%b want result=%h zero=%b ill=0",
                         i, result, zero, illegal_op, er[i], ez[i]);
            end
        end
    endtask

    task automatic test_shift();
        logic [3:0]  ops[5] = '{OP_SRA, OP_SRL, OP_SLL, OP_SLL, OP_SRA};
        logic [31:0] as[5]  = '{32'h80000000, 32'h80000000, 32'h1, 32'h1, 32'h40000000};
        logic [31:0] bs[5]  = '{32'h3F, 32'h3F, 32'h20, 32'h1F, 32'hFFFFFFE1};
        logic [31:0] er[5]  = '{32'hFFFFFFFF, 32'h1, 32'h1, 32'h80000000, 32'h20000000};
        for (int i = 0; i < 5; i++) begin
            drive(ops[i], as[i], bs[i], 1'b0);
            n_tests++;
            if (result !== er[i] || zero !== 1'b0 || illegal_op !== 1'b0) begin
                n_fail++;
                $display("FAIL shift[%0d]: got result=%h zero=%b ill=%b want result=%h zero=0 ill=0",
                         i, result, zero, illegal_op, er[i]);
            end
        end
    endtask

    task automatic test_logic();
        logic [3:0]  ops[4] = '{OP_AND, OP_OR, OP_XOR, OP_XOR};
        logic [31:0] as[4]  = '{32'hF0F0F0F0, 32'hF0F0F0F0, 32'h5A5A5A5A, 32'hF0F0F0F0};
        logic [31:0] bs[4]  = '{32'h0F0F0F0F, 32'h0F0F0F0F, 32'h5A5A5A5A, 32'h0F0F0F0F};
        logic [31:0] er[4]  = '{32'h0, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF};
        logic        ez[4]  = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            drive(ops[i], as[i], bs[i], 1'b0);
            n_tests++;
            if (result !== er[i] || zero !== ez[i] || illegal_op !== 1'b0) begin
                n_fail++;
                $display("FAIL logic[%0d]: got result=%h zero=%b ill=%b want result=%h zero=%b ill=0",
                         i, result, zero, illegal_op, er[i], ez[i]);
            end
        end
    endtask

    task automatic test_illegal();
        logic [3:0] ops[6] = '{4'b1111, 4'b1001, 4'b1110, 4'b1010, 4'b1011, 4'b1100};
        for (int i = 0; i < 6; i++) begin
            drive(ops[i], $urandom, $urandom, 1'b0);
            n_tests++;
            if (result !== 32'h0 || zero !== 1'b0 || illegal_op !== 1'b1) begin
                n_fail++;
                $display("FAIL illegal[%b]: got result=%h zero=%b ill=%b want result=0 zero=0 ill=1",
                         ops[i], result, zero, illegal_op);
            end
        end
    endtask

    task automatic test_random_comb();
        logic [31:0] a, b, er;
        logic [3:0]  op;
        logic        legal;
        for (int i = 0; i < 150; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = (i % 4 == 0) ? a : $urandom;
            model_alu(op, a, b, er, legal);
            drive(op, a, b, 1'b0);
            n_tests++;
            if (result !== er || zero !== (legal && er == 32'h0) || illegal_op !== !legal) begin
                n_fail++;
                $display("FAIL random_comb[%0d] op=%b a=%h b=%h: got result=%h zero=%b ill=%b want result=%h zero=%b ill=%b",
                         i, op, a, b, result, zero, illegal_op, er, legal && er == 32'h0, !legal);
            end
        end
    endtask

    task automatic test_registered();
        logic [32:0] exp;
        // ADD 2+3 captured with valid
        drive(OP_ADD, 32'd2, 32'd3, 1'b1);
        exp_q.push_back({1'b0, 32'd5});
        @(posedge clk); #1;
        n_tests++;
        if (out_valid !== 1'b1 || exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL reg_valid: got out_valid=%b want 1", out_valid);
        end else begin
            exp = exp_q.pop_front();
            n_tests++;
            if ({zero_q, result_q} !== exp) begin
                n_fail++;
                $display("FAIL reg_add: got zero_q=%b result_q=%h want zero_q=%b result_q=%h",
                         zero_q, result_q, exp[32], exp[31:0]);
            end
        end
        // invalid cycle: registered copy holds 5
        drive(OP_ADD, 32'd7, 32'd9, 1'b0);
        @(posedge clk); #1;
        n_tests++;
        if (out_valid !== 1'b0 || result_q !== 32'd5 || zero_q !== 1'b0) begin
            n_fail++;
            $display("FAIL reg_hold: got out_valid=%b result_q=%h zero_q=%b want 0/00000005/0",
                     out_valid, result_q, zero_q);
        end
        // capture a zero result, then reset between edges
        drive(OP_SUB, 32'h55, 32'h55, 1'b1);
        @(posedge clk); #1;
        n_tests++;
        if (out_valid !== 1'b1 || zero_q !== 1'b1 || result_q !== 32'h0) begin
            n_fail++;
            $display("FAIL reg_zero: got out_valid=%b zero_q=%b result_q=%h want 1/1/00000000",
                     out_valid, zero_q, result_q);
        end
        drive(OP_ADD, 32'd10, 32'd20, 1'b1);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if (result_q !== 32'h0 || zero_q !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reg_async_rst: got result_q=%h zero_q=%b out_valid=%b want 0/0/0",
                     result_q, zero_q, out_valid);
        end
        n_tests++;
        if (result !== 32'd30) begin
            n_fail++;
            $display("FAIL rst_comb: got result=%h want 0000001e", result);
        end
        @(negedge clk);
        rst = 1'b0;
        // first edge after reset release samples normally
        drive(OP_SUB, 32'd9, 32'd4, 1'b1);
        @(posedge clk); #1;
        n_tests++;
        if (out_valid !== 1'b1 || result_q !== 32'd5 || zero_q !== 1'b0) begin
            n_fail++;
            $display("FAIL reg_after_rst: got out_valid=%b result_q=%h zero_q=%b want 1/00000005/0",
                     out_valid, result_q, zero_q);
        end
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b, er;
        logic [3:0]  op;
        logic        legal, v, prev_v;
        logic [32:0] exp;
        prev_v = 1'b1;  // last valid driven by test_registered
        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = (i % 5 == 0) ? a : $urandom;
            v  = ($urandom_range(0, 3) != 0);
            model_alu(op, a, b, er, legal);
            drive(op, a, b, v);
            if (v) exp_q.push_back({legal && er == 32'h0, er});
            @(posedge clk); #1;
            n_tests++;
            if (out_valid !== v) begin
                n_fail++;
                $display("FAIL b2b_valid[%0d]: got out_valid=%b want %b", i, out_valid, v);
            end
            if (out_valid === 1'b1) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_underflow[%0d]: got out_valid=1 want no output", i);
                end else begin
                    exp = exp_q.pop_front();
                    if ({zero_q, result_q} !== exp) begin
                        n_fail++;
                        $display("FAIL b2b_data[%0d]: got zero_q=%b result_q=%h want zero_q=%b result_q=%h",
                                 i, zero_q, result_q, exp[32], exp[31:0]);
                    end
                end
            end
            prev_v = v;
        end
        drive(OP_ADD, 32'h0, 32'h0, 1'b0);
        @(posedge clk); #1;
        n_tests++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_drain: got pending=%0d out_valid=%b (prev_v=%b) want 0/0",
                     exp_q.size(), out_valid, prev_v);
        end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        test_reset();
        test_addsub();
        test_compare();
        test_shift();
        test_logic();
        test_illegal();
        test_random_comb();
        test_registered();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
